// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared scanner state encoding, matrix size and column priority helper
package key_pkg;
    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } key_state_t;

    // Lowest-index column pulled low; multi-key presses resolve to the leftmost column.
    function automatic logic [1:0] lowest_low(input logic [COLS-1:0] c);
        lowest_low = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!c[i]) lowest_low = 2'(i);
        end
    endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - one-clk-wide scan tick every F_CLK/F_SCAN cycles
module scan_tick_gen #(
    parameter int F_CLK  = 50000000,
    parameter int F_SCAN = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int DIV = F_CLK / F_SCAN;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/matrix_key_scanner.sv
// rtl/matrix_key_scanner.sv - 4x4 keypad scanner with debounce and valid/ready key output
module matrix_key_scanner
    import key_pkg::*;
#(
    parameter int F_CLK          = 50000000,
    parameter int F_SCAN         = 1000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       key_overrun
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS);

    logic             tick;
    logic [COLS-1:0]  col_meta, col_s;
    key_state_t       state, state_nxt;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [1:0]       col_idx, col_idx_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
    logic             col_low;
    logic             confirm;

    scan_tick_gen #(
        .F_CLK (F_CLK),
        .F_SCAN(F_SCAN)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_s    <= '1;
        end else begin
            col_meta <= col;
            col_s    <= col_meta;
        end
    end

    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign col_low  = ~col_s[col_idx];
    assign row      = ~(4'b0001 << row_idx);
    assign key_held = (state == HELD) || (state == RELEASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SCAN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        row_idx_nxt = row_idx;
        col_idx_nxt = col_idx;
        cnt_nxt     = cnt;
        confirm     = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (col_s != {COLS{1'b1}}) begin
                        col_idx_nxt = lowest_low(col_s);
                        cnt_nxt     = '0;
                        state_nxt   = DEBOUNCE;
                    end else begin
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_low) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_nxt = HELD;
                            confirm   = 1'b1;
                        end
                    end else begin
                        state_nxt   = SCAN;
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end
                HELD: begin
                    if (!col_low) begin
                        cnt_nxt   = '0;
                        state_nxt = RELEASE;
                    end
                end
                RELEASE: begin
                    if (col_low) begin
                        state_nxt = HELD;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_nxt   = SCAN;
                            row_idx_nxt = row_idx + 2'd1;
                        end
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx <= 2'd0;
            col_idx <= 2'd0;
            cnt     <= '0;
        end else begin
            row_idx <= row_idx_nxt;
            col_idx <= col_idx_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // A confirm while the consumer is still sitting on an old code drops the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            key_overrun <= 1'b0;
            if (confirm) begin
                if (!key_valid || key_ready) begin
                    key_code  <= {row_idx, col_idx};
                    key_valid <= 1'b1;
                end else begin
                    key_overrun <= 1'b1;
                end
            end else if (key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_matrix_key_scanner.sv
// tb/tb_matrix_key_scanner.sv - scoreboard bench for matrix_key_scanner with a modelled keypad
module tb_matrix_key_scanner;
    localparam int F_CLK  = 1000;
    localparam int F_SCAN = 100;
    localparam int DEB    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic        key_held;
    logic        key_overrun;
    logic [15:0] pressed = 16'd0;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int ovr_cnt   = 0;
    int exp_q[$];
    logic [3:0] exp_rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    matrix_key_scanner #(
        .F_CLK         (F_CLK),
        .F_SCAN        (F_SCAN),
        .DEBOUNCE_TICKS(DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .col        (col),
        .row        (row),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_held   (key_held),
        .key_overrun(key_overrun)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its column low while its row is driven low.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_row_change(input string tag, input int budget, output int n);
        logic [3:0] r0;
        r0 = row;
        n = 0;
        while (row == r0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(row != r0), 1);
    endtask

    task automatic wait_held(input string tag, input logic lvl, input int budget);
        int n;
        n = 0;
        while (key_held !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(key_held), 32'(lvl));
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (key_valid) valid_cnt++;
            if (key_overrun) ovr_cnt++;
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) check("sb_depth", 32'(exp_q.size()), 1);
                else check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v0;

        cycles(3);
        check("rst_row", 32'(row), 32'(4'b1110));
        check("rst_valid", 32'(key_valid), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_overrun", 32'(key_overrun), 0);
        check("rst_code", 32'(key_code), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            wait_row_change("idle_wait", 20, n);
            check("idle_row", 32'(row), 32'(exp_rows[i]));
            if (i > 0) check("idle_period", n, 10);
        end
        check("idle_valid", valid_cnt, 0);

        // Key 10 with the consumer always ready
        v0 = valid_cnt;
        exp_q.push_back(10);
        pressed[10] = 1'b1;
        wait_held("k10_held", 1'b1, 200);
        cycles(10);
        pressed[10] = 1'b0;
        cycles(25);
        check("k10_held_after_rel", 32'(key_held), 1);
        wait_held("k10_release", 1'b0, 30);
        check("k10_next_row", 32'(row), 32'(4'b0111));
        check("k10_valid_cycles", valid_cnt - v0, 1);

        // Bounce on row 0, col 1: two low ticks then high
        wait_row_change("bnc_sync", 20, n);
        check("bnc_row0", 32'(row), 32'(4'b1110));
        v0 = valid_cnt;
        pressed[1] = 1'b1;
        cycles(25);
        check("bnc_frozen", 32'(row), 32'(4'b1110));
        pressed[1] = 1'b0;
        wait_row_change("bnc_resume", 20, n);
        check("bnc_next_row", 32'(row), 32'(4'b1101));
        check("bnc_held", 32'(key_held), 0);
        check("bnc_valid", valid_cnt - v0, 0);

        // Key 5 unconsumed, then key 6 overruns
        key_ready = 1'b0;
        v0 = ovr_cnt;
        exp_q.push_back(5);
        pressed[5] = 1'b1;
        wait_held("k5_held", 1'b1, 200);
        cycles(2);
        check("k5_valid", 32'(key_valid), 1);
        check("k5_code", 32'(key_code), 5);
        pressed[5] = 1'b0;
        wait_held("k5_release", 1'b0, 60);
        pressed[6] = 1'b1;
        wait_held("k6_held", 1'b1, 200);
        cycles(3);
        check("k6_overrun", ovr_cnt - v0, 1);
        check("k6_code_kept", 32'(key_code), 5);
        check("k6_valid", 32'(key_valid), 1);
        pressed[6] = 1'b0;
        wait_held("k6_release", 1'b0, 60);
        key_ready = 1'b1;
        cycles(3);
        check("k5_drained", 32'(key_valid), 0);
        check("k5_sb_empty", 32'(exp_q.size()), 0);

        // Reset while holding key 9 with a pending code
        key_ready = 1'b0;
        pressed[9] = 1'b1;
        wait_held("k9_held", 1'b1, 200);
        cycles(2);
        check("k9_valid", 32'(key_valid), 1);
        check("k9_code", 32'(key_code), 9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_row", 32'(row), 32'(4'b1110));
        check("mid_rst_valid", 32'(key_valid), 0);
        check("mid_rst_held", 32'(key_held), 0);
        check("mid_rst_overrun", 32'(key_overrun), 0);
        check("mid_rst_code", 32'(key_code), 0);
        pressed[9] = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        key_ready = 1'b1;
        v0 = valid_cnt;
        wait_row_change("rst_restart", 20, n);
        check("rst_restart_row", 32'(row), 32'(4'b1101));
        check("rst_no_valid", valid_cnt - v0, 0);

        // Two columns on row 0 at once: lowest column wins
        v0 = valid_cnt;
        exp_q.push_back(0);
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        wait_held("k0_held", 1'b1, 200);
        pressed[0] = 1'b0;
        pressed[3] = 1'b0;
        wait_held("k0_release", 1'b0, 60);
        check("k0_valid_cycles", valid_cnt - v0, 1);
        check("final_sb_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/matrix_key_scanner.md
MATRIX_KEY_SCANNER -- requirements
Module: matrix_key_scanner

Interface
REQ-001 SHALL have parameter F_CLK, default 50000000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter F_SCAN, default 1000, meaning the scan tick rate in Hz.
REQ-003 SHALL have parameter DEBOUNCE_TICKS, default 20, meaning the number of consecutive stable scan ticks that confirm a press or a release.
REQ-004 SHALL have port `clk`, input, 1 bit: the single system clock.
REQ-005 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port `col`, input, 4 bits: keypad column lines, pulled up, low = key closed on the driven row.
REQ-007 SHALL have port `row`, output, 4 bits: keypad row drive, active-low, at most one bit low.
REQ-008 SHALL have port `key_code`, output, 4 bits: confirmed key index, equal to row_idx*4+col_idx.
REQ-009 SHALL have port `key_valid`, output, 1 bit: `key_code` is pending for the consumer.
REQ-010 SHALL have port `key_ready`, input, 1 bit: the consumer accepts `key_code`.
REQ-011 SHALL have port `key_held`, output, 1 bit: the confirmed key is still held down.
REQ-012 SHALL have port `key_overrun`, output, 1 bit: one-cycle pulse when a confirmed press is dropped.

Function
REQ-013 SHALL generate a one-`clk`-wide scan tick every F_CLK/F_SCAN cycles; all logic SHALL be clocked by `clk` only (no derived clocks).
REQ-014 SHALL synchronise `col` through two flops before any use.
REQ-015 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-016 In SCAN, on each tick, SHALL sample the synced `col` for the current row and then rotate `row` 1110->1101->1011->0111->1110 (wraps).
REQ-017 In SCAN, on a tick with any synced `col` bit low, SHALL latch row_idx and the lowest-index low col_idx, freeze `row`, clear the counter, and enter DEBOUNCE.
REQ-018 In DEBOUNCE, on each tick, SHALL increment the counter if the latched column is low, otherwise SHALL return to SCAN and resume rotation at the next row.
REQ-019 In DEBOUNCE, when the counter reaches DEBOUNCE_TICKS, SHALL enter HELD and present the code per REQ-022..REQ-024.
REQ-020 In HELD, SHALL drive `key_held`=1, keep `row` frozen, and on a tick with the latched column high SHALL clear the counter and enter RELEASE.
REQ-021 In RELEASE, SHALL count consecutive high ticks of the latched column, return to HELD on any low tick, and enter SCAN (rotating) at DEBOUNCE_TICKS; `key_held` SHALL stay 1 during RELEASE.
REQ-022 On confirm with `key_valid`=0, SHALL load `key_code` and set `key_valid`=1 on the next `clk` edge (latency 1 cycle after the confirming tick).
REQ-023 SHALL hold `key_valid`=1 and keep `key_code` stable until a `clk` edge with `key_ready`=1, then SHALL clear `key_valid`.
REQ-024 On confirm with `key_valid`=1 and `key_ready`=0, SHALL keep the old code, drop the new one, and pulse `key_overrun` for one cycle.
REQ-025 On confirm coinciding with `key_valid`=1 and `key_ready`=1, SHALL load the new code with `key_valid` remaining 1 (no overrun).
REQ-026 Only one key SHALL be tracked at a time; other columns and rows SHALL be ignored outside SCAN.
REQ-027 The counter width SHALL be $clog2(DEBOUNCE_TICKS+1) and SHALL saturate, never wrap.

Reset
REQ-028 While `rst_n`=0, SHALL set state=SCAN, `row`=4'b1110, counters=0, synchronisers=4'b1111, `key_code`=0, and `key_valid`, `key_held`, `key_overrun`=0.
REQ-029 Reset assertion mid-press SHALL discard any pending code; after release of reset, scanning SHALL restart at row 0.

Structure
REQ-030 Package key_pkg SHALL hold the state enum and the ROWS=4/COLS=4 constants.
REQ-031 The tick prescaler SHALL be the sub-module scan_tick_gen (parameters F_CLK, F_SCAN; ports `clk`, `rst_n`, `tick`).

Verification (F_CLK=1000, F_SCAN=100 => tick every 10 clk, DEBOUNCE_TICKS=3)
REQ-032 Idle columns 4'b1111 -> `row` cycles 1110,1101,1011,0111,1110 every 10 clk; `key_valid` remains 0.
REQ-033 Hold col[2] low while row=1011 for 5 ticks, `key_ready`=1 -> `key_code`=10, `key_valid` high for exactly one cycle, `key_held`=1 until 3 high ticks after release.
REQ-034 Bounce col[1] low for 2 ticks then high -> no `key_valid`, scanning resumes at the next row.
REQ-035 Press key 5, `key_ready`=0, release, then press key 6 -> `key_code` stays 5, `key_overrun` pulses once; raising `key_ready` clears `key_valid`.
REQ-036 Assert `rst_n`=0 during HELD with `key_valid`=1 -> all outputs 0 and `row`=1110 immediately; scanning restarts after reset deasserts.
REQ-037 Press col[0] and col[3] together on row 0 -> `key_code`=0.
